// File: rtl/alu_pwr_pkg.sv
// alu_pwr_pkg: state encoding and default delays for the ALU power-sequencing controller
package alu_pwr_pkg;
  typedef enum logic [2:0] {
    PS_OFF     = 3'd0,
    PS_PWR_UP  = 3'd1,
    PS_RST_REL = 3'd2,
    PS_ON      = 3'd3,
    PS_DRAIN   = 3'd4,
    PS_ISO_ON  = 3'd5
  } alu_pwr_state_e;
  localparam int ISO_DLY_DEF       = 2;
  localparam int SETTLE_DLY_DEF    = 8;
  localparam int RST_HOLD_DEF      = 2;
  localparam int DRAIN_TIMEOUT_DEF = 64;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/alu_pwr_ctrl_timer.sv
// pwr_seq_timer: loadable down-counter that parks at zero
module pwr_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/alu_pwr_ctrl.sv
// alu_pwr_ctrl: orders power/isolation/reset of the ALU domain on up/down requests.
// Define ALU_PWR_CTRL_TIMEOUT_EN to abort a stuck DRAIN back to ON with an err pulse.
module alu_pwr_ctrl
  import alu_pwr_pkg::*;
#(
  parameter int ISO_DLY       = ISO_DLY_DEF,
  parameter int SETTLE_DLY    = SETTLE_DLY_DEF,
  parameter int RST_HOLD      = RST_HOLD_DEF,
  parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_down_req,
  input  logic       pwr_up_req,
  input  logic       alu_busy,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       alu_rst_n,
  output logic [2:0] pwr_state,
  output logic       done,
  output logic       err
);
  localparam int CW = $clog2(max3(SETTLE_DLY, ISO_DLY, RST_HOLD) + 1);
  alu_pwr_state_e state, nxt;
  logic          tzero, tload, timeout, pwr_d, iso_d, rst_d, done_d;
  logic [CW-1:0] tinit;
`ifdef ALU_PWR_CTRL_TIMEOUT_EN
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  logic [DW-1:0] dcnt;
  always_ff @(posedge clk) begin
    if (!rst_n) dcnt <= '0;
    else dcnt <= (state == PS_DRAIN && alu_busy && !timeout) ? dcnt + 1'b1 : '0;
  end
  assign timeout = state == PS_DRAIN && alu_busy && dcnt == DW'(DRAIN_TIMEOUT - 1);
`else
  assign timeout = DRAIN_TIMEOUT < 0;
`endif
  // One timer shared by all fixed-length states, loaded on entry with length-1
  assign tload = nxt != state && nxt inside {PS_PWR_UP, PS_RST_REL, PS_ISO_ON};
  assign tinit = nxt == PS_PWR_UP  ? CW'(SETTLE_DLY - 1) :
                 nxt == PS_RST_REL ? CW'(RST_HOLD - 1) : CW'(ISO_DLY - 1);
  pwr_seq_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tload),
    .value (tinit),
    .zero  (tzero)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= PS_OFF;
      alu_pwr_en <= 1'b0;
      iso_en     <= 1'b1;
      alu_rst_n  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= nxt;
      alu_pwr_en <= pwr_d;
      iso_en     <= iso_d;
      alu_rst_n  <= rst_d;
      done       <= done_d;
      err        <= timeout;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      PS_OFF:     if (pwr_up_req) nxt = PS_PWR_UP;
      PS_PWR_UP:  if (tzero) nxt = PS_RST_REL;
      PS_RST_REL: if (tzero) nxt = PS_ON;
      PS_ON:      if (pwr_down_req) nxt = PS_DRAIN;
      PS_DRAIN:   nxt = !alu_busy ? PS_ISO_ON : timeout ? PS_ON : PS_DRAIN;
      PS_ISO_ON:  if (tzero) nxt = PS_OFF;
      default:    nxt = PS_OFF;
    endcase
  end
  // Outputs are decoded from the next state so they register together with it
  always_comb begin
    pwr_d  = nxt != PS_OFF;
    rst_d  = !(nxt inside {PS_OFF, PS_PWR_UP});
    iso_d  = !(nxt inside {PS_ON, PS_DRAIN});
    done_d = nxt != state && nxt inside {PS_ON, PS_OFF} && !timeout;
  end
  assign pwr_state = state;
endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// tb_alu_pwr_ctrl: directed vector table plus randomized run against a schedule-queue model
module tb_alu_pwr_ctrl;
  localparam int ISO = 2, SETTLE = 8, RSTH = 2, DT = 64;
  logic clk = 1'b0, rst_n = 1'b0, up = 1'b0, down = 1'b0, busy = 1'b0;
  logic alu_pwr_en, iso_en, alu_rst_n, done, err;
  logic [2:0] pwr_state;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  alu_pwr_ctrl #(.ISO_DLY(ISO), .SETTLE_DLY(SETTLE), .RST_HOLD(RSTH), .DRAIN_TIMEOUT(DT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwr_down_req (down),
    .pwr_up_req   (up),
    .alu_busy     (busy),
    .alu_pwr_en   (alu_pwr_en),
    .iso_en       (iso_en),
    .alu_rst_n    (alu_rst_n),
    .pwr_state    (pwr_state),
    .done         (done),
    .err          (err)
  );
  typedef struct {
    logic rn, u, d, b;
    int n;
    logic [2:0] st;
    logic p, i, r, dn;
  } vec_t;
  function automatic vec_t v(input logic rn, u, d, b, input int n, input logic [2:0] st,
                             input logic p, i, r, dn);
    vec_t x;
    x.rn = rn; x.u = u; x.d = d; x.b = b; x.n = n; x.st = st; x.p = p; x.i = i; x.r = r; x.dn = dn;
    return x;
  endfunction
  function automatic logic [7:0] act();
    return {pwr_state, alu_pwr_en, iso_en, alu_rst_n, done, err};
  endfunction
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h (state,pwr,iso,rst,done,err)", name, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Model: a queue of scheduled states for fixed-length sequences, otherwise a resting state
  int m_cur = 0, m_prev = 0, m_bc = 0, m_q[$];
  logic m_err = 1'b0;
  task automatic model(input logic rn, u, d, b);
    m_prev = m_cur;
    m_err = 1'b0;
    if (!rn) begin
      m_q.delete();
      m_cur = 0;
      m_prev = 0;
      m_bc = 0;
    end else if (m_q.size() > 0) m_cur = m_q.pop_front();
    else if (m_cur == 0 && u) begin
      m_cur = 1;
      repeat (SETTLE - 1) m_q.push_back(1);
      repeat (RSTH) m_q.push_back(2);
      m_q.push_back(3);
    end else if (m_cur == 3 && d) begin
      m_cur = 4;
      m_bc = 0;
    end else if (m_cur == 4) begin
      if (!b) begin
        m_cur = 5;
        repeat (ISO - 1) m_q.push_back(5);
        m_q.push_back(0);
      end
`ifdef ALU_PWR_CTRL_TIMEOUT_EN
      else begin
        m_bc++;
        if (m_bc == DT) begin
          m_cur = 3;
          m_err = 1'b1;
        end
      end
`endif
    end
  endtask
  function automatic logic [7:0] m_exp();
    logic [2:0] s;
    s = 3'(m_cur);
    return {s, m_cur != 0, m_cur inside {0, 1, 2, 5}, m_cur >= 2,
            (m_cur == 0 || m_cur == 3) && m_cur != m_prev && !m_err, m_err};
  endfunction
  vec_t tbl[$];
  initial begin
    int mode;
    tbl.push_back(v(0,0,0,0,2, 0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,3, 0,0,1,0,0));
    tbl.push_back(v(1,1,0,0,1, 1,1,1,0,0));
    tbl.push_back(v(1,0,0,0,7, 1,1,1,0,0));
    tbl.push_back(v(1,0,0,0,2, 2,1,1,1,0));
    tbl.push_back(v(1,0,0,0,1, 3,1,0,1,1));
    tbl.push_back(v(1,0,0,0,1, 3,1,0,1,0));
    tbl.push_back(v(1,0,1,0,1, 4,1,0,1,0));
    tbl.push_back(v(1,0,0,0,2, 5,1,1,1,0));
    tbl.push_back(v(1,0,0,0,1, 0,0,1,0,1));
    tbl.push_back(v(1,0,1,0,2, 0,0,1,0,0));
    tbl.push_back(v(1,1,0,0,1, 1,1,1,0,0));
    tbl.push_back(v(1,1,0,0,3, 1,1,1,0,0));
    tbl.push_back(v(0,1,0,0,1, 0,0,1,0,0));
    tbl.push_back(v(1,1,0,0,1, 1,1,1,0,0));
    tbl.push_back(v(1,0,0,0,7, 1,1,1,0,0));
    tbl.push_back(v(1,0,0,0,2, 2,1,1,1,0));
    tbl.push_back(v(1,0,0,0,1, 3,1,0,1,1));
    tbl.push_back(v(1,1,0,0,2, 3,1,0,1,0));
    tbl.push_back(v(1,0,1,1,1, 4,1,0,1,0));
    tbl.push_back(v(1,0,0,1,9, 4,1,0,1,0));
    tbl.push_back(v(1,0,0,0,2, 5,1,1,1,0));
    tbl.push_back(v(1,0,0,0,1, 0,0,1,0,1));
    tbl.push_back(v(1,1,0,0,1, 1,1,1,0,0));
    tbl.push_back(v(1,0,0,0,7, 1,1,1,0,0));
    tbl.push_back(v(1,0,0,0,2, 2,1,1,1,0));
    tbl.push_back(v(1,0,0,0,1, 3,1,0,1,1));
    tbl.push_back(v(1,0,1,0,1, 4,1,0,1,0));
    tbl.push_back(v(1,0,0,0,1, 5,1,1,1,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,2, 0,0,1,0,0));
    foreach (tbl[k]) begin
      for (int c = 0; c < tbl[k].n; c++) begin
        rst_n = tbl[k].rn; up = tbl[k].u; down = tbl[k].d; busy = tbl[k].b;
        tick();
        check($sformatf("row%0d.%0d", k, c), act(),
              {tbl[k].st, tbl[k].p, tbl[k].i, tbl[k].r, tbl[k].dn, 1'b0});
      end
    end
    rst_n = 1'b0; up = 1'b0; down = 1'b0; busy = 1'b0;
    tick();
    model(1'b0, 1'b0, 1'b0, 1'b0);
    check("rand_reset", act(), m_exp());
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) mode = int'($urandom_range(0, 3));
      rst_n = $urandom_range(0, 249) != 0;
      up    = mode == 3 ? 1'b1 : $urandom_range(0, 9) < 3;
      down  = mode == 3 ? 1'b1 : $urandom_range(0, 9) < 3;
      busy  = mode == 2 ? 1'b1 : mode == 3 ? 1'b0 : $urandom_range(0, 3) == 0;
      tick();
      model(rst_n, up, down, busy);
      check($sformatf("rand%0d", c), act(), m_exp());
      check($sformatf("iso_inv%0d", c), {7'd0, iso_en}, {7'd0, iso_en | !alu_pwr_en | !alu_rst_n});
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alu_pwr_ctrl.md
# alu_pwr_ctrl

Power-sequencing controller that drives the `alu_pwr_en` / `iso_en` pair consumed by the ALU power domain and its clamped output stage. It accepts power-down and power-up requests from the system and orders the domain controls so the domain never loses power unclamped and never leaves clamp before its local reset is released:
- Down: drain, then isolate, then power off.
- Up: power on, hold reset, release reset, then de-isolate.

It also generates the domain-local reset and reports status back to the requester.

## Interface
- `ISO_DLY`, default 2: cycles `iso_en` is held before `alu_pwr_en` drops (≥1).
- `SETTLE_DLY`, default 8: cycles after `alu_pwr_en` rises with `alu_rst_n` held low (≥1).
- `RST_HOLD`, default 2: cycles after `alu_rst_n` release before `iso_en` drops (≥1).
- `DRAIN_TIMEOUT`, default 64: drain timeout limit. Used only when `ALU_PWR_CTRL_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `pwr_down_req`  in  1: level request; sampled only in ON.
- `pwr_up_req`  in  1: level request; sampled only in OFF.
- `alu_busy`  in  1: ALU operation in flight.
- `alu_pwr_en`  out  1: domain power enable.
- `iso_en`  out  1: output isolation/clamp enable.
- `alu_rst_n`  out  1: domain-local reset, active-low.
- `pwr_state`  out  3: current state encoding.
- `done`  out  1: one-cycle pulse on entry to ON or OFF.
- `err`  out  1: one-cycle pulse on drain timeout. Tied 0 when the feature is compiled out.

## Operation
All outputs are registered and are a pure function of the state, except the `done` and `err` pulses.

States (`pwr_en` / `iso` / `alu_rst_n`):
- **OFF (0/1/0)**: reset state. If `pwr_up_req` is high, go to PWR_UP.
- **PWR_UP (1/1/0)**: count `SETTLE_DLY` cycles, then go to RST_REL.
- **RST_REL (1/1/1)**: count `RST_HOLD` cycles, then go to ON.
- **ON (1/0/1)**: if `pwr_down_req` is high, go to DRAIN.
- **DRAIN (1/0/1)**: when `alu_busy` is low, go to ISO_ON.
- **ISO_ON (1/1/1)**: count `ISO_DLY` cycles, then go to OFF.

Rules:
- Requests are ignored in every state other than the one that samples them.
- Holding a request level re-triggers at the next ON/OFF visit. The requester deasserts on `done`.
- If both requests are high simultaneously, the state decides: ON honours down, OFF honours up.
- `iso_en` is high in every state where `alu_pwr_en` is low or `alu_rst_n` is low. This is an invariant.
- `done` is high during the first cycle in ON or OFF, but not on the OFF entered by reset.
- Counters load `DLY-1` on state entry, decrement each cycle, and the state exits at 0.
  - Counter width is `$clog2(max(SETTLE_DLY, ISO_DLY, RST_HOLD) + 1)`.
  - Each state lasts exactly its parameter in cycles.
- Synchronous reset in any state forces OFF outputs (0/1/0) at the next edge. The counter clears and no `done` is produced.

## Timing
Power-down latency (request high at edge k, `alu_busy` low):
- Edge k: enter DRAIN.
- Edge k+1: enter ISO_ON; `iso_en` = 1.
- Edge k+1+`ISO_DLY`: enter OFF; `alu_pwr_en` = 0, `done` = 1.
- If `alu_busy` is high, DRAIN stretches until the first edge that samples it low.

Power-up latency (request high at edge j):
- Edge j: `alu_pwr_en` = 1.
- Edge j+`SETTLE_DLY`: `alu_rst_n` = 1.
- Edge j+`SETTLE_DLY`+`RST_HOLD`: `iso_en` = 0, `done` = 1.

`pwr_state` encoding: OFF=0, PWR_UP=1, RST_REL=2, ON=3, DRAIN=4, ISO_ON=5.

## Configuration
`ALU_PWR_CTRL_TIMEOUT_EN`:
- **Defined**: DRAIN counts cycles with `alu_busy` high. After `DRAIN_TIMEOUT` consecutive cycles, the FSM returns to ON and pulses `err` for one cycle. It does not isolate or power off, and no `done` is produced. A fresh request is needed to retry.
- **Undefined**: DRAIN waits indefinitely, `err` is constant 0, and no timeout counter is built.

## Structure
- Package `alu_pwr_pkg`:
  - state enum `alu_pwr_state_e` with the encodings above;
  - default delay constants.
- Sub-module `pwr_seq_timer`: loadable down-counter with a `load` / `value` / `zero` interface, width parameterised. The FSM instantiates one of it and reuses it across the delay states.

## Test plan
1. Reset with defaults → outputs 0/1/0, `pwr_state`=0, no `done`. Assert `pwr_up_req` at edge 5 → `alu_pwr_en`=1 after edge 5, `alu_rst_n`=1 after edge 13, `iso_en`=0 and `done` after edge 15.
2. From ON, pulse `pwr_down_req` with `alu_busy`=0 → `iso_en`=1 one edge after DRAIN entry, `alu_pwr_en`=0 exactly 2 cycles later, `done` for 1 cycle.
3. `pwr_down_req` with `alu_busy` high for 10 cycles → `pwr_state` stays 4 for 10 cycles. `iso_en` rises only after `busy` falls.
4. Both requests held high → full ON→OFF→ON cycling, one `done` per ON/OFF entry. Check the `iso_en` invariant every cycle.
5. `rst_n` low during PWR_UP and during ISO_ON → 0/1/0 at the next edge, counter restarts cleanly on the next request.
6. With `ALU_PWR_CTRL_TIMEOUT_EN` and `DRAIN_TIMEOUT`=64, `alu_busy` stuck high → after 64 cycles, return to ON, `err` pulses for 1 cycle, `iso_en` never asserts.
